ahb_arbiter_slave: RTL and testbench
====================================

// Module: ahb_arbiter_slave
// PURPOSE
//  Per-slave AHB arbiter, downstream of the per-master address decoders.
//  Collects one hreq bit from each master's decoder for this slave and issues a
//  registered one-hot hgrant, which is fed back to the decoders. Drives the
//  address-phase and data-phase master select indices for the slave-side muxes.
//  Round-robin fairness; bursts hold the grant; MAX_BEATS caps tenure.
// PARAMETERS
//  SLAVE_X_MASTER_NUM  3   number of masters that can reach this slave (>=2)
//  MAX_BEATS           16  accepted beats per tenure before forced handover;
//                          0 = no limit
//  MIDX (localparam)       $clog2(SLAVE_X_MASTER_NUM), index width
// PORTS
//  hclk              in   1       clock, all logic on rising edge
//  hreset            in   1       reset, synchronous, active-high
//  hreq              in   M       per-master request from decoder (pre-gated by htrans!=IDLE)
//  htrans            in   M x 2   htrans_type per master (IDLE/BUSY/NONSEQ/SEQ)
//  hready            in   1       slave hreadyout; a transfer phase completes when 1
//  hgrant            out  M       one-hot grant, registered
//  hmaster_addr      out  MIDX    owner of the current address phase, registered
//  hmaster_data      out  MIDX    owner of the current data phase, registered
//  hmaster_data_vld  out  1       data phase holds a real NONSEQ/SEQ transfer
//  hsel              out  1       combinational slave select for the current address phase
// BEHAVIOUR
//  Reset (hreset=1 at an edge, any state, any hready):
//   - state=ARB_IDLE; hgrant=0; hmaster_addr=0; hmaster_data=0; hmaster_data_vld=0.
//   - beat_cnt=0; last_owner=M-1, so master 0 has top priority after reset.
//  Round-robin winner: the first requesting index scanning last_owner+1 .. last_owner (mod M).
//  States:
//   ARB_IDLE
//    - hgrant=0.
//    - On hready & |hreq: hgrant<=onehot(winner); hmaster_addr<=winner;
//      last_owner<=winner; beat_cnt<=0; go to ARB_OWN.
//    - hready=0: no action.
//   ARB_OWN (owner = hmaster_addr)
//    - hready & htrans[owner] in {NONSEQ,SEQ}: beat_cnt++ (saturating).
//    - Release when hready & (!hreq[owner] | htrans[owner]==IDLE):
//      - other requests pending: grant winner directly, no idle cycle.
//      - otherwise: go to ARB_IDLE with hgrant=0.
//    - Force when MAX_BEATS!=0 & beat_cnt==MAX_BEATS & another master requests:
//      hgrant<=0; go to ARB_SWITCH.
//    - BUSY holds the grant; hready=0 freezes hgrant and hmaster_addr.
//   ARB_SWITCH
//    - hgrant=0.
//    - On hready=1: grant winner excluding the old owner; go to ARB_OWN.
//    - If no other requester remains: go to ARB_IDLE.
//  Pipeline:
//   - On every hready=1 edge: hmaster_data<=hmaster_addr;
//     hmaster_data_vld<=hsel & htrans[hmaster_addr] in {NONSEQ,SEQ}.
//   - hready=0: both hold.
//  hsel = (state!=ARB_IDLE) & hreq[hmaster_addr] & htrans[hmaster_addr] in {NONSEQ,SEQ}.
//  Latency: request to hgrant is 1 edge (with hready=1); hgrant to data-phase select is +1 hready edge.
//  A release and a new request in the same cycle: the new request competes in that same arbitration.
//  A non-owner hreq during ARB_OWN is ignored until release or force.
//  hgrant is always one-hot or zero; hmaster_addr < M always.
// TESTING
//  1 Reset; hreq=001, htrans0=NONSEQ, hready=1 -> next edge hgrant=001, hmaster_addr=0;
//    following edge hmaster_data=0, hmaster_data_vld=1.
//  2 From IDLE, hreq=111; each master does a single beat then IDLE -> grant order
//    001,010,100,001 with no idle cycle between grants.
//  3 Owner 0 in SEQ burst; hready=0 for 3 cycles; hreq[1] rises -> hgrant=001 and
//    hmaster_addr=0 unchanged through the stall; 010 only after owner 0 goes IDLE with hready=1.
//  4 MAX_BEATS=4; master 0 streams SEQ; hreq[1]=1 -> after 4th accepted beat hgrant=000
//    (ARB_SWITCH); next hready=1 edge hgrant=010, hmaster_addr=1.
//  5 hreset=1 in ARB_OWN with hready=0 -> next edge all outputs 0, ARB_IDLE; then
//    hreq=100 -> hgrant=100.
//  6 Owner releases with no other requests -> ARB_IDLE, hgrant=000, hsel=0,
//    hmaster_data_vld=0 after the next hready edge.

Source files
------------

// File: rtl/ahb_arbiter_slave.sv
// Per-slave AHB arbiter: round-robin grant, bursts hold the grant,
// optional tenure cap, address/data phase owner tracking.
module ahb_arbiter_slave #(
   parameter  int SLAVE_X_MASTER_NUM = 3,
   parameter  int MAX_BEATS          = 16,
   localparam int MIDX               = $clog2(SLAVE_X_MASTER_NUM)
) (
   input  logic                               hclk,
   input  logic                               hreset,
   input  logic [SLAVE_X_MASTER_NUM-1:0]      hreq,
   input  logic [SLAVE_X_MASTER_NUM-1:0][1:0] htrans,
   input  logic                               hready,
   output logic [SLAVE_X_MASTER_NUM-1:0]      hgrant,
   output logic [MIDX-1:0]                    hmaster_addr,
   output logic [MIDX-1:0]                    hmaster_data,
   output logic                               hmaster_data_vld,
   output logic                               hsel
);

   localparam int M  = SLAVE_X_MASTER_NUM;
   localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
   // With no cap the counter just saturates at all-ones and is never compared.
   localparam logic [CW-1:0] BEAT_SAT =
      (MAX_BEATS > 0) ? CW'(MAX_BEATS) : {CW{1'b1}};
   localparam logic [1:0] HT_IDLE = 2'b00;

   typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_SWITCH} state_t;

   state_t          state_q, state_d;
   logic [M-1:0]    hgrant_q, hgrant_d;
   logic [MIDX-1:0] addr_q, addr_d;
   logic [MIDX-1:0] data_q, data_d;
   logic            vld_q, vld_d;
   logic [MIDX-1:0] last_q, last_d;
   logic [CW-1:0]   beat_q, beat_d;

   logic [M-1:0]    others;
   logic [MIDX-1:0] win_all, win_oth, gnt_idx;
   logic            owner_act, owner_rel, cap_hit, gnt_en;

   function automatic logic [M-1:0] onehot(input logic [MIDX-1:0] idx);
      logic [M-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // First requester after last, wrapping back round to last itself.
   function automatic logic [MIDX-1:0] rr_pick(input logic [M-1:0] req,
                                               input logic [MIDX-1:0] last);
      logic [MIDX-1:0] pick;
      logic            found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= M; i++) begin
         idx = (int'(last) + i) % M;
         if (!found && req[idx]) begin
            pick  = MIDX'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign owner_act = htrans[addr_q][1];
   assign owner_rel = !hreq[addr_q] || (htrans[addr_q] == HT_IDLE);
   assign others    = hreq & ~onehot(addr_q);
   assign win_all   = rr_pick(hreq, last_q);
   assign win_oth   = rr_pick(others, last_q);
   assign cap_hit   = (MAX_BEATS != 0) && (beat_q == BEAT_SAT);
   assign hsel      = (state_q != ARB_IDLE) && hreq[addr_q] && owner_act;

   always_comb begin
      state_d  = state_q;
      hgrant_d = hgrant_q;
      addr_d   = addr_q;
      data_d   = data_q;
      vld_d    = vld_q;
      last_d   = last_q;
      beat_d   = beat_q;
      gnt_en   = 1'b0;
      gnt_idx  = '0;

      if (hready) begin
         data_d = addr_q;
         vld_d  = hsel;
      end

      unique case (state_q)
         ARB_IDLE: begin
            hgrant_d = '0;
            if (hready && |hreq) begin
               gnt_en  = 1'b1;
               gnt_idx = win_all;
            end
         end
         ARB_OWN: begin
            if (hready) begin
               if (owner_act && beat_q != BEAT_SAT)
                  beat_d = beat_q + CW'(1);
               if (owner_rel) begin
                  if (|others) begin
                     gnt_en  = 1'b1;
                     gnt_idx = win_oth;
                  end else begin
                     state_d  = ARB_IDLE;
                     hgrant_d = '0;
                  end
               end else if (cap_hit && |others) begin
                  state_d  = ARB_SWITCH;
                  hgrant_d = '0;
               end
            end
         end
         ARB_SWITCH: begin
            hgrant_d = '0;
            if (hready) begin
               if (|others) begin
                  gnt_en  = 1'b1;
                  gnt_idx = win_oth;
               end else begin
                  state_d = ARB_IDLE;
               end
            end
         end
         default: begin
            state_d  = ARB_IDLE;
            hgrant_d = '0;
         end
      endcase

      if (gnt_en) begin
         state_d  = ARB_OWN;
         hgrant_d = onehot(gnt_idx);
         addr_d   = gnt_idx;
         last_d   = gnt_idx;
         beat_d   = '0;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q  <= ARB_IDLE;
         hgrant_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         vld_q    <= 1'b0;
         last_q   <= MIDX'(M - 1);
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         hgrant_q <= hgrant_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         last_q   <= last_d;
         beat_q   <= beat_d;
      end
   end

   assign hgrant           = hgrant_q;
   assign hmaster_addr     = addr_q;
   assign hmaster_data     = data_q;
   assign hmaster_data_vld = vld_q;

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Scoreboard bench for ahb_arbiter_slave: three masters, tenure cap of 4.
// Stimulus queues expected outputs per cycle; a negedge monitor checks them.
module tb_ahb_arbiter_slave;

   localparam logic [1:0] I  = 2'b00;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [1:0] SQ = 2'b11;
   localparam logic [4:0] G  = 5'b00001;
   localparam logic [4:0] A  = 5'b00010;
   localparam logic [4:0] D  = 5'b00100;
   localparam logic [4:0] V  = 5'b01000;
   localparam logic [4:0] S  = 5'b10000;
   localparam logic [4:0] ALL = 5'b11111;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      req;
   logic [2:0][1:0] ht;
   logic            rdy;
   logic [2:0]      g;
   logic [1:0]      a, d;
   logic            v, s;

   typedef struct packed {
      int         cyc;
      logic [4:0] m;
      logic [2:0] g;
      logic [1:0] a;
      logic [1:0] d;
      logic       v;
      logic       s;
   } exp_t;

   exp_t  sb[$];
   string nq[$];
   int    cyc = 0;
   int    n_run = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ahb_arbiter_slave #(.SLAVE_X_MASTER_NUM(3), .MAX_BEATS(4)) dut (
      .hclk(clk),
      .hreset(rst),
      .hreq(req),
      .htrans(ht),
      .hready(rdy),
      .hgrant(g),
      .hmaster_addr(a),
      .hmaster_data(d),
      .hmaster_data_vld(v),
      .hsel(s)
   );

   always @(negedge clk) begin : mon
      exp_t  e;
      string nm;
      logic  ok;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e  = sb.pop_front();
         nm = nq.pop_front();
         n_run++;
         ok = (e.cyc == cyc);
         if (e.m[0] && g !== e.g) ok = 1'b0;
         if (e.m[1] && a !== e.a) ok = 1'b0;
         if (e.m[2] && d !== e.d) ok = 1'b0;
         if (e.m[3] && v !== e.v) ok = 1'b0;
         if (e.m[4] && s !== e.s) ok = 1'b0;
         if (!ok) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got g=%b a=%0d d=%0d v=%b s=%b want g=%b a=%0d d=%0d v=%b s=%b mask=%b",
                     nm, cyc, g, a, d, v, s, e.g, e.a, e.d, e.v, e.s, e.m);
         end
      end
   end

   task automatic cy(input logic r, input logic [2:0] rq,
                     input logic [1:0] t2, input logic [1:0] t1,
                     input logic [1:0] t0, input logic rd);
      @(posedge clk);
      #1;
      rst = r;
      req = rq;
      ht  = {t2, t1, t0};
      rdy = rd;
   endtask

   task automatic ex(input string nm, input logic [4:0] m,
                     input logic [2:0] eg, input logic [1:0] ea,
                     input logic [1:0] ed, input logic ev, input logic es);
      exp_t e;
      e.cyc = cyc;
      e.m   = m;
      e.g   = eg;
      e.a   = ea;
      e.d   = ed;
      e.v   = ev;
      e.s   = es;
      sb.push_back(e);
      nq.push_back(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout n_run=%0d", n_run);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req = '0;
      ht  = '0;
      rdy = 1'b1;
      cy(1, 3'b000, I, I, I, 1);
      cy(1, 3'b000, I, I, I, 0);
      cy(0, 3'b000, I, I, I, 1); ex("rst", ALL, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);

      // single master, single beat, then release to idle
      cy(0, 3'b001, I, I, NS, 1); ex("t1_idle", G|S, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b001, I, I, NS, 1); ex("t1_grant", G|A|S, 3'b001, 2'd0, 2'd0, 1'b0, 1'b1);
      cy(0, 3'b000, I, I, I, 1);  ex("t1_data", G|D|V|S, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0);
      cy(0, 3'b000, I, I, I, 1);  ex("t6_idle", G|V|S, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b000, I, I, I, 1);  ex("t6_hold", G|V|S, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);

      cy(1, 3'b000, I, I, I, 1);
      cy(0, 3'b000, I, I, I, 1);  ex("rst2", ALL, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);

      // round robin with back-to-back grants
      cy(0, 3'b111, NS, NS, NS, 1); ex("t2_c1", G|S, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b111, NS, NS, NS, 1); ex("t2_g0", G|A|S, 3'b001, 2'd0, 2'd0, 1'b0, 1'b1);
      cy(0, 3'b110, NS, NS, I, 1);  ex("t2_b0", G|D|V|S, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0);
      cy(0, 3'b110, NS, NS, I, 1);  ex("t2_g1", G|A|S, 3'b010, 2'd1, 2'd0, 1'b0, 1'b1);
      cy(0, 3'b100, NS, I, I, 1);   ex("t2_b1", G|D|V, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0);
      cy(0, 3'b101, NS, I, NS, 1);  ex("t2_g2", G|A|S, 3'b100, 2'd2, 2'd0, 1'b0, 1'b1);
      cy(0, 3'b001, I, I, NS, 1);   ex("t2_b2", G|D|V, 3'b100, 2'd2, 2'd2, 1'b1, 1'b0);
      cy(0, 3'b001, I, I, NS, 1);   ex("t2_g0b", G|A, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b000, I, I, I, 1);    ex("t2_b0b", G|D|V, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0);
      cy(0, 3'b000, I, I, I, 1);    ex("t2_idle", G, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);

      // burst with a three-cycle stall and a competing request
      cy(0, 3'b001, I, I, NS, 1);  ex("t3_c1", G, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b001, I, I, NS, 1);  ex("t3_g0", G|A, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 0); ex("t3_s1", G|A|D|V, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 0); ex("t3_s2", G|A|D|V, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 0); ex("t3_s3", G|A|D|V, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 1); ex("t3_s4", G|A, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b010, I, NS, I, 1);  ex("t3_hold", G|A|D|V, 3'b001, 2'd0, 2'd0, 1'b1, 1'b0);
      cy(0, 3'b010, I, NS, I, 1);  ex("t3_g1", G|A, 3'b010, 2'd1, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b000, I, I, I, 1);   ex("t3_b1", G, 3'b010, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b000, I, I, I, 1);   ex("t3_idle", G, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);

      // tenure cap forces a handover through the switch state
      cy(0, 3'b001, I, I, NS, 1);  ex("t4_c1", G, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b011, I, NS, NS, 1); ex("t4_g0", G|A, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 1); ex("t4_b1", G, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 1); ex("t4_b2", G, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 1); ex("t4_b3", G, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 1); ex("t4_b4", A, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b011, I, NS, SQ, 1); ex("t4_force", G|A, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b010, I, NS, I, 1);  ex("t4_sw", G|A, 3'b010, 2'd1, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b010, I, NS, I, 1);  ex("t4_own1", G|A, 3'b010, 2'd1, 2'd0, 1'b0, 1'b0);

      // reset while owning with hready low
      cy(1, 3'b010, I, NS, I, 0);  ex("t5_pre", G, 3'b010, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b100, NS, I, I, 1);  ex("t5_rst", ALL, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b100, NS, I, I, 1);  ex("t5_g2", G|A|D|V|S, 3'b100, 2'd2, 2'd0, 1'b0, 1'b1);
      cy(0, 3'b000, I, I, I, 1);   ex("t5_b2", G|D|V|S, 3'b100, 2'd2, 2'd2, 1'b1, 1'b0);
      cy(0, 3'b000, I, I, I, 1);   ex("t6_rel", G|S, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0);
      cy(0, 3'b000, I, I, I, 1);   ex("t6_vld", G|D|V|S, 3'b000, 2'd0, 2'd2, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         $display("FAIL drain %0d expectations never checked", sb.size());
         n_fail += sb.size();
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
